ltc2308_responder: RTL and testbench

Synthesizable SPI responder that emulates the LTC2308 8-channel 12-bit ADC at the far end of the CONVST/SCK/SDI/SDO link. It lets the ADC interface master run in loopback on the FPGA and in simulation without the physical converter. Analog inputs come from a packed 8×12-bit bus. The block samples on CONVST, models conversion time, shifts the result out MSB-first on SDO, and captures the 6-bit configuration word from SDI for the next conversion.

---
 rtl/ltc2308_pkg.sv | 40 ++++
 rtl/ltc2308_responder_edge_sync.sv | 34 +++
 rtl/ltc2308_responder.sv | 116 +++++++++++
 tb/tb_ltc2308_responder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ltc2308_pkg.sv
// rtl/ltc2308_pkg.sv - LTC2308 responder types, config reset value and result function
package ltc2308_pkg;

  typedef enum logic [1:0] {S_IDLE, S_CONVERTING, S_READY, S_SHIFTING} state_t;

  typedef struct packed {
    logic       sd;
    logic       os;
    logic [1:0] s1s0;
    logic       uni;
    logic       slp;
  } cfg_t;

  localparam int   CFG_BITS  = 6;
  localparam cfg_t CFG_RESET = '{sd: 1'b1, os: 1'b0, s1s0: 2'b00, uni: 1'b1, slp: 1'b0};

  // Converter transfer function for one sample under the given config.
  function automatic logic [11:0] ltc_result(input logic [95:0] chan_data, input cfg_t cfg);
    logic [11:0]        ch [8];
    logic [11:0]        a;
    logic [11:0]        b;
    logic signed [12:0] d;
    logic signed [12:0] half;
    logic [11:0]        r;
    for (int n = 0; n < 8; n++) ch[n] = chan_data[12*n +: 12];
    a    = cfg.os ? ch[{cfg.s1s0, 1'b1}] : ch[{cfg.s1s0, 1'b0}];
    b    = cfg.os ? ch[{cfg.s1s0, 1'b0}] : ch[{cfg.s1s0, 1'b1}];
    d    = $signed({1'b0, a}) - $signed({1'b0, b});
    half = d >>> 1;
    if (cfg.sd) begin
      r = cfg.uni ? ch[{cfg.s1s0, cfg.os}] : (ch[{cfg.s1s0, cfg.os}] ^ 12'h800);
    end else if (cfg.uni) begin
      r = d[12] ? 12'h000 : d[11:0];
    end else begin
      r = half[11:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/ltc2308_responder_edge_sync.sv
// rtl/ltc2308_responder_edge_sync.sv - 2-FF synchronizer with registered level and edge flags
module edge_sync (
  input  logic clk,
  input  logic reset_count,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;

  // level, rise and fall are registered together so they describe the same instant.
  always_ff @(posedge clk or posedge reset_count) begin
    if (reset_count) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1    <= din;
      s2    <= s1;
      s3    <= s2;
      level <= s2;
      rise  <= s2 & ~s3;
      fall  <= ~s2 & s3;
    end
  end

endmodule

// File: rtl/ltc2308_responder.sv
// rtl/ltc2308_responder.sv - LTC2308 ADC emulator on the CONVST/SCK/SDI/SDO link
module ltc2308_responder
  import ltc2308_pkg::*;
#(
  parameter int CONV_CYCLES = 80,
  parameter int FRAME_BITS  = 12
) (
  input  logic        clk,
  input  logic        reset_count,
  input  logic [95:0] chan_data,
  input  logic        ADC_CONVST,
  input  logic        ADC_SCK,
  input  logic        ADC_SDI,
  output logic        ADC_SDO,
  output logic [2:0]  cfg_chan,
  output logic        cfg_uni,
  output logic        cfg_sd,
  output logic        frame_done,
  output logic        proto_err
);

  localparam int             CW         = $clog2(CONV_CYCLES + 1);
  localparam int             BW         = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0]  CONV_LAST  = CW'(CONV_CYCLES - 1);
  localparam logic [BW-1:0]  FRAME_LAST = BW'(FRAME_BITS - 1);
  localparam logic [BW-1:0]  CFG_CNT    = BW'(CFG_BITS);

  logic cv_level, cv_rise, cv_fall;
  logic sck_level, sck_rise, sck_fall;
  logic sdi_level, sdi_rise, sdi_fall;

  edge_sync u_sync_convst (.clk(clk), .reset_count(reset_count), .din(ADC_CONVST),
                           .level(cv_level), .rise(cv_rise), .fall(cv_fall));
  edge_sync u_sync_sck    (.clk(clk), .reset_count(reset_count), .din(ADC_SCK),
                           .level(sck_level), .rise(sck_rise), .fall(sck_fall));
  edge_sync u_sync_sdi    (.clk(clk), .reset_count(reset_count), .din(ADC_SDI),
                           .level(sdi_level), .rise(sdi_rise), .fall(sdi_fall));

  state_t              state;
  logic [CW-1:0]       conv_cnt;
  logic [BW-1:0]       bit_cnt;
  logic [11:0]         hold;
  logic [CFG_BITS-1:0] cfg_sr;
  cfg_t                cfg;
  cfg_t                cfg_next;

  // Only the first CFG_BITS captured SDI bits are kept; later bits leave the register alone.
  assign cfg_next = (bit_cnt < CFG_CNT) ? cfg_t'({cfg_sr[CFG_BITS-2:0], sdi_level}) : cfg_t'(cfg_sr);

  assign cfg_chan = {cfg.s1s0, cfg.os};
  assign cfg_uni  = cfg.uni;
  assign cfg_sd   = cfg.sd;

  always_ff @(posedge clk or posedge reset_count) begin
    if (reset_count) begin
      state      <= S_IDLE;
      conv_cnt   <= '0;
      bit_cnt    <= '0;
      hold       <= '0;
      cfg_sr     <= '0;
      cfg        <= CFG_RESET;
      ADC_SDO    <= 1'b0;
      frame_done <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sck_rise) proto_err <= 1'b1;
          if (cv_rise) begin
            hold     <= ltc_result(chan_data, cfg);
            conv_cnt <= '0;
            state    <= S_CONVERTING;
          end
        end
        S_CONVERTING: begin
          if (sck_rise || cv_rise) proto_err <= 1'b1;
          if (conv_cnt == CONV_LAST) begin
            ADC_SDO <= hold[11];
            state   <= S_READY;
          end else begin
            conv_cnt <= conv_cnt + 1'b1;
          end
        end
        S_READY, S_SHIFTING: begin
          if (cv_rise) begin
            // Abort: config stays as it was, a fresh sample starts converting.
            proto_err <= 1'b1;
            hold      <= ltc_result(chan_data, cfg);
            conv_cnt  <= '0;
            bit_cnt   <= '0;
            ADC_SDO   <= 1'b0;
            state     <= S_CONVERTING;
          end else if (sck_rise) begin
            cfg_sr <= cfg_next;
            if (bit_cnt == FRAME_LAST) begin
              cfg        <= cfg_next;
              frame_done <= 1'b1;
              ADC_SDO    <= 1'b0;
              bit_cnt    <= '0;
              state      <= S_IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              state   <= S_SHIFTING;
            end
          end else if (sck_fall && state == S_SHIFTING) begin
            hold    <= {hold[10:0], 1'b0};
            ADC_SDO <= hold[10];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ltc2308_responder.sv
// tb/tb_ltc2308_responder.sv - self-checking bench for ltc2308_responder
module tb_ltc2308_responder;

  localparam int CONV = 80;
  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        reset_count = 1'b1;
  logic [95:0] chan_data;
  logic        ADC_CONVST, ADC_SCK, ADC_SDI;
  logic        ADC_SDO;
  logic [2:0]  cfg_chan;
  logic        cfg_uni, cfg_sd, frame_done, proto_err;

  int          checks = 0;
  int          failures = 0;
  int          fd_count = 0;
  logic [5:0]  mcfg;
  logic [5:0]  pend_cfg = 6'b100010;
  logic [11:0] got;

  always #5 clk = ~clk;

  ltc2308_responder #(.CONV_CYCLES(CONV), .FRAME_BITS(12)) dut (
    .clk(clk), .reset_count(reset_count), .chan_data(chan_data),
    .ADC_CONVST(ADC_CONVST), .ADC_SCK(ADC_SCK), .ADC_SDI(ADC_SDI), .ADC_SDO(ADC_SDO),
    .cfg_chan(cfg_chan), .cfg_uni(cfg_uni), .cfg_sd(cfg_sd),
    .frame_done(frame_done), .proto_err(proto_err)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference transfer function; config bits are {sd, os, s1, s0, uni, slp}.
  function automatic int model(input logic [95:0] cd, input logic [5:0] c);
    int ch[8];
    int p, a, b, d, t;
    for (int n = 0; n < 8; n++) ch[n] = int'(cd[12*n +: 12]);
    if (c[5]) begin
      t = ch[4*int'(c[3]) + 2*int'(c[2]) + int'(c[4])];
      return c[1] ? t : (t ^ 'h800);
    end
    p = 2*int'(c[3]) + int'(c[2]);
    a = ch[2*p];
    b = ch[2*p + 1];
    if (c[4]) begin t = a; a = b; b = t; end
    d = a - b;
    if (c[1]) return (d < 0) ? 0 : ((d > 4095) ? 4095 : d);
    return (d >>> 1) & 'hFFF;
  endfunction

  // Config model: follows reset and every completed frame, checks the cfg outputs there.
  always @(negedge clk) begin
    if (reset_count) begin
      mcfg = 6'b100010;
    end else if (frame_done) begin
      fd_count++;
      mcfg = pend_cfg;
      check("cfg_chan", int'(cfg_chan), 4*int'(mcfg[3]) + 2*int'(mcfg[2]) + int'(mcfg[4]));
      check("cfg_sd", int'(cfg_sd), int'(mcfg[5]));
      check("cfg_uni", int'(cfg_uni), int'(mcfg[1]));
    end
  end

  task automatic pulse_convst();
    ADC_CONVST = 1'b1;
    tick(3);
    ADC_CONVST = 1'b0;
  endtask

  task automatic sck_bits(input logic [11:0] w, input int n, output logic [11:0] rd);
    rd = '0;
    for (int i = 0; i < n; i++) begin
      ADC_SDI = w[11-i];
      tick(HALF);
      rd = {rd[10:0], ADC_SDO};
      ADC_SCK = 1'b1;
      tick(HALF);
      ADC_SCK = 1'b0;
    end
  endtask

  task automatic frame(input logic [11:0] sdi_word, input int abort_after, output logic [11:0] rd);
    int exp, fd0;
    fd0 = fd_count;
    exp = model(chan_data, mcfg);
    pulse_convst();
    tick(CONV + 10);
    if (abort_after > 0) begin
      sck_bits(sdi_word, abort_after, rd);
      exp = model(chan_data, mcfg);
      pulse_convst();
      tick(CONV + 10);
      check("abort_proto_err", int'(proto_err), 1);
      check("abort_no_frame_done", fd_count - fd0, 0);
    end
    pend_cfg = sdi_word[11:6];
    sck_bits(sdi_word, 12, rd);
    tick(8);
    check("result", int'(rd), exp);
    check("frame_done_once", fd_count - fd0, 1);
    check("sdo_idle", int'(ADC_SDO), 0);
  endtask

  initial begin
    ADC_CONVST = 1'b0;
    ADC_SCK    = 1'b0;
    ADC_SDI    = 1'b0;
    chan_data  = '0;
    tick(4);
    check("rst_sdo", int'(ADC_SDO), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_proto_err", int'(proto_err), 0);
    check("rst_cfg_chan", int'(cfg_chan), 0);
    check("rst_cfg_sd", int'(cfg_sd), 1);
    check("rst_cfg_uni", int'(cfg_uni), 1);
    reset_count = 1'b0;
    tick(4);

    chan_data[11:0] = 12'hA5C;
    frame(12'h880, 0, got);
    check("lit_a5c", int'(got), 'hA5C);

    chan_data[59:48] = 12'h123;
    frame(12'hA80, 0, got);
    frame(12'h880, 0, got);
    check("lit_pipeline_ch4", int'(got), 'h123);

    chan_data[35:24] = 12'd100;
    chan_data[47:36] = 12'd300;
    frame(12'h180, 0, got);
    frame(12'h580, 0, got);
    check("lit_diff_clamp", int'(got), 0);
    frame(12'h100, 0, got);
    check("lit_diff_swap", int'(got), 200);
    frame(12'h880, 0, got);
    check("lit_diff_bipolar", int'(got), 'hF9C);

    chan_data[23:12] = 12'h000;
    frame(12'hC00, 0, got);
    frame(12'h880, 0, got);
    check("lit_se_bipolar", int'(got), 'h800);

    for (int k = 0; k < 24; k++) begin
      chan_data = {$urandom(), $urandom(), $urandom()};
      frame(12'($urandom_range(0, 4095)), 0, got);
    end
    check("no_proto_err_legal", int'(proto_err), 0);

    chan_data = {$urandom(), $urandom(), $urandom()};
    frame(12'h880, 3, got);

    frame(12'hA80, 0, got);
    chan_data = '1;
    pulse_convst();
    tick(20);
    ADC_SCK = 1'b1;
    tick(HALF);
    ADC_SCK = 1'b0;
    tick(4);
    check("early_sck_proto_err", int'(proto_err), 1);
    tick(CONV + 10);
    sck_bits(12'hFFF, 5, got);
    tick(HALF);
    check("mid_shift_sdo", int'(ADC_SDO), 1);
    reset_count = 1'b1;
    #1;
    check("midrst_sdo", int'(ADC_SDO), 0);
    check("midrst_proto_err", int'(proto_err), 0);
    check("midrst_frame_done", int'(frame_done), 0);
    check("midrst_cfg_chan", int'(cfg_chan), 0);
    check("midrst_cfg_sd", int'(cfg_sd), 1);
    check("midrst_cfg_uni", int'(cfg_uni), 1);
    tick(3);
    reset_count = 1'b0;
    tick(4);

    chan_data = {$urandom(), $urandom(), $urandom()};
    frame(12'($urandom_range(0, 4095)), 0, got);
    frame(12'h880, 0, got);
    check("post_reset_proto_err", int'(proto_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
